rf_op_sequencer: RTL and testbench

//  Command-driven micro-sequencer that sits directly in front of the 2R/1W register file.

---
 rtl/rf_op_sequencer_pkg.sv | 21 ++
 rtl/rf_op_sequencer_alu.sv | 34 +++
 rtl/rf_op_sequencer.sv | 131 +++++++++++++
 tb/tb_rf_op_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_op_sequencer_pkg.sv
// Shared opcode constants and FSM state encoding for the RF op sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package rf_op_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/rf_op_sequencer_alu.sv
// Combinational ALU for the sequencer EX stage; arithmetic wraps, shifts use low log2(BW_DATA) bits of B.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
module rf_alu
    import rf_op_sequencer_pkg::*;
#(
    parameter int BW_DATA = 16
) (
    input  logic [2:0]         i_op,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic [BW_DATA-1:0] i_imm,
    output logic [BW_DATA-1:0] o_result
);

    localparam int SHW = (BW_DATA > 1) ? $clog2(BW_DATA) : 1;

    logic [SHW-1:0] w_sh;
    assign w_sh = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << w_sh;
            OP_SHR:  o_result = i_a >> w_sh;
            default: o_result = i_imm;
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Single-client micro-sequencer for a 2R/1W RF: IDLE->RD->EX->WB, one op per 4 cycles.
// Latency: accept at edge k, RF write commits at edge k+3. Backpressure: o_cmd_ready only in IDLE.
module rf_op_sequencer
    import rf_op_sequencer_pkg::*;
#(
    parameter int BW_DATA = 16,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [2:0]         i_cmd_op,
    input  logic [BW_ADDR-1:0] i_cmd_rs0,
    input  logic [BW_ADDR-1:0] i_cmd_rs1,
    input  logic [BW_ADDR-1:0] i_cmd_rd,
    input  logic [BW_DATA-1:0] i_cmd_imm,
    output logic [BW_ADDR-1:0] o_rf_rd_addr0,
    output logic [BW_ADDR-1:0] o_rf_rd_addr1,
    input  logic [BW_DATA-1:0] i_rf_rd_data0,
    input  logic [BW_DATA-1:0] i_rf_rd_data1,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data,
    output logic               o_done,
    output logic [BW_DATA-1:0] o_result,
    output logic               o_zero
);

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic [2:0]           r_op;
    logic [BW_ADDR-1:0]   r_rs0;
    logic [BW_ADDR-1:0]   r_rs1;
    logic [BW_ADDR-1:0]   r_rd;
    logic [BW_DATA-1:0]   r_imm;
    logic [BW_DATA-1:0]   r_a;
    logic [BW_DATA-1:0]   r_b;
    logic [BW_DATA-1:0]   r_res;
    logic [BW_DATA-1:0]   r_result;
    logic                 r_zero;
    logic [BW_DATA-1:0]   w_alu;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write-side strobes are masked by i_rst so a reset landing in WB never commits.
    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        o_rf_wr_en  = 1'b0;
        o_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                w_accept    = i_cmd_valid;
                if (i_cmd_valid) begin
                    w_next = S_RD;
                end
            end
            S_RD: w_next = S_EX;
            S_EX: w_next = S_WB;
            S_WB: begin
                o_rf_wr_en = ~i_rst;
                o_done     = ~i_rst;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= '0;
            r_rs0    <= '0;
            r_rs1    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_op  <= i_cmd_op;
                r_rs0 <= i_cmd_rs0;
                r_rs1 <= i_cmd_rs1;
                r_rd  <= i_cmd_rd;
                r_imm <= i_cmd_imm;
            end
            if (r_state == S_RD) begin
                r_a <= i_rf_rd_data0;
                r_b <= i_rf_rd_data1;
            end
            if (r_state == S_EX) begin
                r_res <= w_alu;
            end
            if (r_state == S_WB) begin
                r_result <= r_res;
                r_zero   <= (r_res == '0);
            end
        end
    end

    rf_alu #(
        .BW_DATA (BW_DATA)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu)
    );

    // Read addresses come straight from the captured command, so they hold outside RD.
    assign o_rf_rd_addr0 = r_rs0;
    assign o_rf_rd_addr1 = r_rs1;
    assign o_rf_wr_addr  = r_rd;
    assign o_rf_wr_data  = r_res;
    assign o_result      = r_result;
    assign o_zero        = r_zero;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer with a behavioural 16x16 register file and a reference op model.
module tb_rf_op_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_op;
    logic [3:0]  i_cmd_rs0, i_cmd_rs1, i_cmd_rd;
    logic [15:0] i_cmd_imm;
    logic [3:0]  o_rf_rd_addr0, o_rf_rd_addr1;
    logic [15:0] i_rf_rd_data0, i_rf_rd_data1;
    logic        o_rf_wr_en;
    logic [3:0]  o_rf_wr_addr;
    logic [15:0] o_rf_wr_data;
    logic        o_done;
    logic [15:0] o_result;
    logic        o_zero;

    int total = 0;
    int bad   = 0;

    rf_op_sequencer #(.BW_DATA(16), .BW_ADDR(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_rs0(i_cmd_rs0), .i_cmd_rs1(i_cmd_rs1),
        .i_cmd_rd(i_cmd_rd), .i_cmd_imm(i_cmd_imm),
        .o_rf_rd_addr0(o_rf_rd_addr0), .o_rf_rd_addr1(o_rf_rd_addr1),
        .i_rf_rd_data0(i_rf_rd_data0), .i_rf_rd_data1(i_rf_rd_data1),
        .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_data(o_rf_wr_data),
        .o_done(o_done), .o_result(o_result), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    // Register file: combinational reads, write on the clock edge.
    logic [15:0] rf_mem [16] = '{default: 16'h0};
    assign i_rf_rd_data0 = rf_mem[o_rf_rd_addr0];
    assign i_rf_rd_data1 = rf_mem[o_rf_rd_addr1];

    int cyc = 0;
    int done_cnt = 0;
    int acc_q[$];
    int wr_cyc_q[$];
    logic [15:0] wr_data_q[$];
    logic [3:0]  wr_addr_q[$];

    always @(posedge i_clk) begin
        if (o_rf_wr_en) begin
            rf_mem[o_rf_wr_addr] <= o_rf_wr_data;
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(o_rf_wr_data);
            wr_addr_q.push_back(o_rf_wr_addr);
        end
        if (o_done) done_cnt <= done_cnt + 1;
        if (i_cmd_valid && o_cmd_ready && !i_rst) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Reference model
    logic [15:0] ref_rf [16] = '{default: 16'h0};

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] imm);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << (b % 16);
            3'd6: return a >> (b % 16);
            default: return imm;
        endcase
    endfunction

    int          obs_lat;
    logic [3:0]  obs_addr;
    logic [15:0] obs_data;
    logic [15:0] exp_res;

    task automatic issue(input logic [2:0] op, input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [3:0] rd, input logic [15:0] imm);
        int n0 = wr_cyc_q.size();
        int waited = 0;
        while (!o_cmd_ready && waited < 20) begin
            @(posedge i_clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            total++; bad++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        i_cmd_valid = 1'b1;
        i_cmd_op = op; i_cmd_rs0 = rs0; i_cmd_rs1 = rs1; i_cmd_rd = rd; i_cmd_imm = imm;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_op  = 3'($urandom);  i_cmd_rs0 = 4'($urandom);
        i_cmd_rs1 = 4'($urandom);  i_cmd_rd  = 4'($urandom);
        i_cmd_imm = 16'($urandom);
        repeat (3) begin @(posedge i_clk); #1; end
        exp_res = ref_op(op, ref_rf[rs0], ref_rf[rs1], imm);
        ref_rf[rd] = exp_res;
        if (wr_cyc_q.size() > n0) begin
            obs_lat = wr_cyc_q[$] - acc_q[$];
            obs_addr = wr_addr_q[$];
            obs_data = wr_data_q[$];
        end else begin
            obs_lat = -1; obs_addr = 4'h0; obs_data = 16'hxxxx;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_op = 3'd7; i_cmd_rs0 = 4'd3; i_cmd_rs1 = 4'd4; i_cmd_rd = 4'd5; i_cmd_imm = 16'hBEEF;
        repeat (3) @(posedge i_clk);
        #1;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", o_cmd_ready); end
        total++; if (o_rf_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", o_rf_wr_en); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_done); end
        total++; if (o_result !== 16'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", o_result); end
        total++; if (o_zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", o_zero); end
        total++; if (o_rf_rd_addr0 !== 4'h0 || o_rf_rd_addr1 !== 4'h0) begin bad++; $display("FAIL rst_rd_addr got=%h/%h exp=0/0", o_rf_rd_addr0, o_rf_rd_addr1); end
        total++; if (o_rf_wr_addr !== 4'h0 || o_rf_wr_data !== 16'h0) begin bad++; $display("FAIL rst_wr_bus got=%h/%h exp=0/0", o_rf_wr_addr, o_rf_wr_data); end
        i_cmd_valid = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_ldi();
        int d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            issue(3'd7, 4'($urandom), 4'($urandom), 4'(i), 16'(i * 3));
            total++; if (obs_lat !== 3) begin bad++; $display("FAIL ldi_latency[%0d] got=%0d exp=3", i, obs_lat); end
            total++; if (obs_data !== 16'(i * 3) || obs_addr !== 4'(i)) begin bad++; $display("FAIL ldi_write[%0d] got=%h@%0d exp=%h@%0d", i, obs_data, obs_addr, 16'(i * 3), i); end
            total++; if (o_result !== 16'(i * 3)) begin bad++; $display("FAIL ldi_result[%0d] got=%h exp=%h", i, o_result, 16'(i * 3)); end
        end
        total++; if (done_cnt - d0 !== 16) begin bad++; $display("FAIL ldi_done_count got=%0d exp=16", done_cnt - d0); end
        total++; if (rf_mem[5] !== 16'd15) begin bad++; $display("FAIL ldi_r5 got=%h exp=000f", rf_mem[5]); end
    endtask

    task automatic test_add_sub();
        issue(3'd7, 4'd0, 4'd0, 4'd1, 16'hFFFF);
        issue(3'd7, 4'd0, 4'd0, 4'd2, 16'h0001);
        issue(3'd0, 4'd1, 4'd2, 4'd3, 16'h0);
        total++; if (rf_mem[3] !== 16'h0000 || o_result !== 16'h0000) begin bad++; $display("FAIL add_wrap got=%h/%h exp=0000", rf_mem[3], o_result); end
        total++; if (o_zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b exp=1", o_zero); end
        issue(3'd1, 4'd2, 4'd1, 4'd4, 16'h0);
        total++; if (rf_mem[4] !== 16'h0002 || o_result !== 16'h0002) begin bad++; $display("FAIL sub_borrow got=%h/%h exp=0002", rf_mem[4], o_result); end
        total++; if (o_zero !== 1'b0) begin bad++; $display("FAIL sub_zero got=%b exp=0", o_zero); end
    endtask

    task automatic test_shift();
        issue(3'd7, 4'd0, 4'd0, 4'd1, 16'h8001);
        issue(3'd7, 4'd0, 4'd0, 4'd2, 16'h0004);
        issue(3'd5, 4'd1, 4'd2, 4'd5, 16'h0);
        total++; if (rf_mem[5] !== 16'h0010) begin bad++; $display("FAIL shl4 got=%h exp=0010", rf_mem[5]); end
        issue(3'd6, 4'd1, 4'd2, 4'd6, 16'h0);
        total++; if (rf_mem[6] !== 16'h0800) begin bad++; $display("FAIL shr4 got=%h exp=0800", rf_mem[6]); end
        issue(3'd7, 4'd0, 4'd0, 4'd2, 16'h0013);
        issue(3'd5, 4'd1, 4'd2, 4'd7, 16'h0);
        total++; if (rf_mem[7] !== 16'h0008) begin bad++; $display("FAIL shl_lowbits got=%h exp=0008", rf_mem[7]); end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        int na;
        issue(3'd7, 4'd0, 4'd0, 4'd3, 16'h0001);
        na = acc_q.size();
        i_cmd_valid = 1'b1;
        i_cmd_op = 3'd0; i_cmd_rs0 = 4'd3; i_cmd_rs1 = 4'd3; i_cmd_rd = 4'd3; i_cmd_imm = 16'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_clk); #1;
            exp_rdy = (i % 4 == 3);
            total++; if (o_cmd_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, o_cmd_ready, exp_rdy); end
        end
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) ref_rf[3] = ref_op(3'd0, ref_rf[3], ref_rf[3], 16'h0);
        total++;
        if (acc_q.size() - na !== 3) begin
            bad++; $display("FAIL b2b_accepts got=%0d exp=3", acc_q.size() - na);
        end else if (acc_q[$] - acc_q[$-1] !== 4 || acc_q[$-1] - acc_q[$-2] !== 4) begin
            bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", acc_q[$-1] - acc_q[$-2], acc_q[$] - acc_q[$-1]);
        end
        total++; if (wr_data_q[$-2] !== 16'd2 || wr_data_q[$-1] !== 16'd4 || wr_data_q[$] !== 16'd8) begin bad++; $display("FAIL b2b_chain got=%h,%h,%h exp=2,4,8", wr_data_q[$-2], wr_data_q[$-1], wr_data_q[$]); end
        total++; if (wr_cyc_q[$] - acc_q[$] !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", wr_cyc_q[$] - acc_q[$]); end
    endtask

    task automatic test_reset_mid();
        int d0, n0;
        issue(3'd7, 4'd0, 4'd0, 4'd7, 16'h1234);
        issue(3'd7, 4'd0, 4'd0, 4'd1, 16'h0011);
        issue(3'd7, 4'd0, 4'd0, 4'd2, 16'h0022);
        d0 = done_cnt; n0 = wr_cyc_q.size();
        i_cmd_valid = 1'b1;
        i_cmd_op = 3'd0; i_cmd_rs0 = 4'd1; i_cmd_rs1 = 4'd2; i_cmd_rd = 4'd7;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rstex_ready got=%b exp=1", o_cmd_ready); end
        total++; if (o_result !== 16'h0 || o_zero !== 1'b1) begin bad++; $display("FAIL rstex_result got=%h/%b exp=0000/1", o_result, o_zero); end
        repeat (4) begin @(posedge i_clk); #1; end
        total++; if (done_cnt !== d0 || wr_cyc_q.size() !== n0) begin bad++; $display("FAIL rstex_no_write got=%0d/%0d exp=%0d/%0d", done_cnt, wr_cyc_q.size(), d0, n0); end
        total++; if (rf_mem[7] !== 16'h1234) begin bad++; $display("FAIL rstex_r7 got=%h exp=1234", rf_mem[7]); end
        // Reset landing in the WB cycle itself.
        i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end
        i_rst = 1'b1;
        #1;
        total++; if (o_rf_wr_en !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL rstwb_strobe got=%b/%b exp=0/0", o_rf_wr_en, o_done); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end
        total++; if (rf_mem[7] !== 16'h1234 || done_cnt !== d0) begin bad++; $display("FAIL rstwb_r7 got=%h/%0d exp=1234/%0d", rf_mem[7], done_cnt, d0); end
    endtask

    task automatic test_logic();
        issue(3'd7, 4'd0, 4'd0, 4'd1, 16'hF0F0);
        issue(3'd7, 4'd0, 4'd0, 4'd2, 16'h0FF0);
        issue(3'd2, 4'd1, 4'd2, 4'd8, 16'h0);
        total++; if (rf_mem[8] !== 16'h00F0) begin bad++; $display("FAIL and got=%h exp=00f0", rf_mem[8]); end
        issue(3'd3, 4'd1, 4'd2, 4'd9, 16'h0);
        total++; if (rf_mem[9] !== 16'hFFF0) begin bad++; $display("FAIL or got=%h exp=fff0", rf_mem[9]); end
        issue(3'd4, 4'd1, 4'd2, 4'd1, 16'h0);
        total++; if (rf_mem[1] !== 16'hFF00 || o_result !== 16'hFF00) begin bad++; $display("FAIL xor_rd_eq_rs0 got=%h/%h exp=ff00", rf_mem[1], o_result); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] a, b, d;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); a = 4'($urandom); b = 4'($urandom_range(0, 15));
            d = 4'($urandom);
            issue(op, a, (i % 5 == 0) ? a : b, d, 16'($urandom));
            total++; if (obs_lat !== 3 || obs_addr !== d) begin bad++; $display("FAIL rnd_write[%0d] got=lat%0d@%0d exp=lat3@%0d", i, obs_lat, obs_addr, d); end
            total++; if (obs_data !== exp_res || o_result !== exp_res) begin bad++; $display("FAIL rnd_data[%0d] op=%0d got=%h/%h exp=%h", i, op, obs_data, o_result, exp_res); end
            total++; if (o_zero !== (exp_res == 16'h0)) begin bad++; $display("FAIL rnd_zero[%0d] got=%b exp=%b", i, o_zero, exp_res == 16'h0); end
        end
        for (int r = 0; r < 16; r++) begin
            total++; if (rf_mem[r] !== ref_rf[r]) begin bad++; $display("FAIL rf_final[%0d] got=%h exp=%h", r, rf_mem[r], ref_rf[r]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b0; i_cmd_valid = 1'b0;
        i_cmd_op = 3'd0; i_cmd_rs0 = 4'd0; i_cmd_rs1 = 4'd0; i_cmd_rd = 4'd0; i_cmd_imm = 16'h0;
        @(negedge i_clk);
        test_reset();
        test_ldi();
        test_add_sub();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        test_logic();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
